// File: rtl/dec_pkg.sv
// Shared definitions for the decoder-sharing controller.
// Contents: codeword/message widths, filler codeword, in-flight tag type,
// and the result-collector state encoding.
package dec_pkg;

  localparam int unsigned CW_W  = 7;
  localparam int unsigned MSG_W = 4;

  localparam logic [CW_W-1:0] FILL_CW = '0;

  // One in-flight codeword: idle marks filler whose result is dropped.
  typedef struct packed {
    logic       idle;
    logic [1:0] ch;
  } tag_t;

  typedef enum logic [1:0] {
    COL_ARMED,
    COL_SHIFT,
    COL_HOLD
  } col_state_e;

endpackage

// File: rtl/dec_tag_fifo.sv
// In-flight tag FIFO: one entry per codeword sent to the core, popped
// when the matching result nibble completes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write wdata_i (dropped and flagged when full without a pop)
//   pop_i       remove head entry (flagged when empty)
//   wdata_i     tag to store
//   rdata_o     head entry
//   empty_o     FIFO empty
//   err_o       sticky overflow/underflow flag, cleared only by reset
module dec_tag_fifo
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  tag_t wdata_i,
  output tag_t rdata_o,
  output logic empty_o,
  output logic err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          err_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if ((push_i && !do_push) || (pop_i && empty_o)) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/dec_share_ctrl.sv
// Round-robin sharing of one serial (7,4) decoder core between N_CH
// requesters. Codewords go out MSB-first under dec_in_flag, filler is sent
// when nobody requests, and 4-bit serial results come back tagged with the
// originating channel in grant order.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-channel codeword available
//   req_cw         channel i codeword at [7i+6:7i]
//   req_ready      one-hot grant pulse, codeword taken this cycle
//   dec_data_in    serial bit to the core
//   dec_in_flag    core consumes dec_data_in this cycle
//   dec_data_out   serial result bit from the core
//   dec_out_flag   result bit valid
//   res_valid      result pulse; res_data/res_ch valid with it
//   res_data       decoded nibble, bit 3 was received first
//   res_ch         channel of res_data
//   err_ovf        sticky tag FIFO overflow/underflow
module dec_share_ctrl
  import dec_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CH_W      = $clog2(N_CH),
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [CW_W*N_CH-1:0] req_cw,
  output logic [N_CH-1:0]      req_ready,
  output logic                 dec_data_in,
  input  logic                 dec_in_flag,
  input  logic                 dec_data_out,
  input  logic                 dec_out_flag,
  output logic                 res_valid,
  output logic [MSG_W-1:0]     res_data,
  output logic [CH_W-1:0]      res_ch,
  output logic                 err_ovf
);

  // Feed path
  logic [CW_W-1:0] tx_sr_q;
  logic [2:0]      tx_cnt_q;
  logic            started_q;
  logic            cur_idle_q;
  logic [CH_W-1:0] cur_ch_q;
  logic [CH_W-1:0] rr_q;

  logic            boundary;
  logic            grant_any;
  logic [CH_W-1:0] grant_ch;
  logic [CW_W-1:0] cw_sel;
  int unsigned     scan;

  // Collect path; only the first three bits are stored, the fourth goes
  // straight into the result register.
  col_state_e       col_q;
  logic [MSG_W-2:0] rx_sr_q;
  logic [1:0]       rx_cnt_q;
  logic             res_valid_q;
  logic [MSG_W-1:0] res_data_q;
  logic [CH_W-1:0]  res_ch_q;

  logic nib_done;
  tag_t tag_head;
  tag_t tag_push;
  logic tag_empty;

  // Before the first consumed bit the reset filler is retired without a
  // tag, so that first in_flag cycle is also an arbitration point.
  assign boundary    = rst_n && dec_in_flag && ((tx_cnt_q == 3'd6) || !started_q);
  assign dec_data_in = tx_sr_q[CW_W-1];

  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    scan      = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan = (32'(rr_q) + k) % N_CH;
      if (!grant_any && req_valid[scan[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_ch  = scan[CH_W-1:0];
      end
    end
  end

  always_comb begin
    cw_sel = FILL_CW;
    for (int unsigned i = 0; i < N_CH; i++)
      if (32'(grant_ch) == i) cw_sel = req_cw[i*CW_W +: CW_W];
  end

  always_comb begin
    req_ready = '0;
    if (boundary && grant_any) req_ready[grant_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_q    <= FILL_CW;
      tx_cnt_q   <= '0;
      started_q  <= 1'b0;
      cur_idle_q <= 1'b1;
      cur_ch_q   <= '0;
      rr_q       <= '0;
    end else if (boundary) begin
      started_q <= 1'b1;
      tx_cnt_q  <= '0;
      if (grant_any) begin
        tx_sr_q    <= cw_sel;
        cur_idle_q <= 1'b0;
        cur_ch_q   <= grant_ch;
        rr_q       <= (32'(grant_ch) == N_CH - 1) ? '0 : grant_ch + 1'b1;
      end else begin
        tx_sr_q    <= FILL_CW;
        cur_idle_q <= 1'b1;
      end
    end else if (dec_in_flag) begin
      tx_sr_q  <= {tx_sr_q[CW_W-2:0], 1'b0};
      tx_cnt_q <= tx_cnt_q + 3'd1;
    end
  end

  assign tag_push.idle = cur_idle_q;
  assign tag_push.ch   = 2'(cur_ch_q);

  assign nib_done = dec_out_flag && (col_q != COL_HOLD) && (rx_cnt_q == 2'd3);

  dec_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (boundary && started_q),
    .pop_i  (nib_done),
    .wdata_i(tag_push),
    .rdata_o(tag_head),
    .empty_o(tag_empty),
    .err_o  (err_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= COL_ARMED;
      rx_sr_q     <= '0;
      rx_cnt_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (col_q)
        COL_ARMED, COL_SHIFT: begin
          if (dec_out_flag) begin
            rx_sr_q  <= {rx_sr_q[MSG_W-3:0], dec_data_out};
            rx_cnt_q <= rx_cnt_q + 2'd1;
            if (rx_cnt_q == 2'd3) begin
              col_q <= COL_HOLD;
              if (!tag_empty && !tag_head.idle) begin
                res_valid_q <= 1'b1;
                res_data_q  <= {rx_sr_q, dec_data_out};
                res_ch_q    <= CH_W'(tag_head.ch);
              end
            end else begin
              col_q <= COL_SHIFT;
            end
          end
        end
        COL_HOLD: if (!dec_out_flag) col_q <= COL_ARMED;
        default:  col_q <= COL_ARMED;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;

endmodule

// File: tb/tb_dec_share_ctrl.sv
module tb_dec_share_ctrl;
  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [7*N-1:0] req_cw = '0;
  logic [N-1:0]   req_ready;
  logic           dec_data_in;
  logic           dec_in_flag = 1'b0;
  logic           dec_data_out = 1'b0;
  logic           dec_out_flag = 1'b0;
  logic           res_valid;
  logic [3:0]     res_data;
  logic [0:0]     res_ch;
  logic           err_ovf;

  dec_share_ctrl #(.N_CH(N), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cw(req_cw),
    .req_ready(req_ready), .dec_data_in(dec_data_in), .dec_in_flag(dec_in_flag),
    .dec_data_out(dec_data_out), .dec_out_flag(dec_out_flag),
    .res_valid(res_valid), .res_data(res_data), .res_ch(res_ch), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits still to be sent, tags in flight, pointer.
  typedef struct { bit idle; int unsigned ch; } mtag_t;
  int unsigned m_rr;
  bit          m_bits[$];
  mtag_t       m_tags[$];
  mtag_t       m_cur;
  bit          m_started, m_err, m_rv;
  logic [3:0]  m_rd;
  int unsigned m_rch;

  // Core emulation: per-cycle result-side slots.
  typedef struct { bit flag; bit b; bit done; logic [3:0] val; } oslot_t;
  oslot_t      out_q[$];
  bit          auto_core = 1'b0;
  bit          force_nib = 1'b0;
  logic [3:0]  forced_val = '0;

  // Snapshot of one cycle: observed (s_) and expected (e_).
  bit          s_din, e_din, s_rv, e_rv, s_err, e_err;
  logic [N-1:0] s_rdy, e_rdy;
  logic [3:0]  s_rd, e_rd;
  int unsigned s_rch, e_rch;

  function automatic void model_reset();
    m_rr = 0; m_bits.delete(); m_bits.push_back(1'b0); m_tags.delete();
    m_cur = '{1'b1, 0}; m_started = 0; m_err = 0; m_rv = 0; m_rd = '0; m_rch = 0;
  endfunction

  function automatic void model_step(input bit inf, input logic [N-1:0] rv,
      input logic [7*N-1:0] cw, input bit nd, input logic [3:0] nv,
      output bit edin, output logic [N-1:0] erdy);
    mtag_t t;
    bit found;
    int unsigned w;
    logic [6:0] c;
    edin = m_bits[0];
    erdy = '0;
    m_rv = 0;
    if (nd) begin
      if (m_tags.size() == 0) m_err = 1;
      else begin
        t = m_tags.pop_front();
        if (!t.idle) begin m_rv = 1; m_rd = nv; m_rch = t.ch; end
      end
    end
    if (inf) begin
      m_bits.delete(0);
      if (m_bits.size() == 0) begin
        if (m_started) begin
          if (m_tags.size() >= DEPTH) m_err = 1;
          else m_tags.push_back(m_cur);
        end
        m_started = 1;
        found = 0; w = 0;
        for (int unsigned k = 0; k < N; k++)
          if (!found && rv[(m_rr + k) % N]) begin found = 1; w = (m_rr + k) % N; end
        if (found) begin
          c = cw[7*w +: 7]; erdy[w] = 1'b1; m_cur = '{1'b0, w}; m_rr = (w + 1) % N;
        end else begin
          c = '0; m_cur = '{1'b1, 0};
        end
        for (int b = 6; b >= 0; b--) m_bits.push_back(c[b]);
      end
    end
  endfunction

  function automatic void sched_nibble(input logic [3:0] v);
    for (int b = 3; b >= 0; b--) out_q.push_back('{1'b1, v[b], b == 0, v});
    out_q.push_back('{1'b0, 1'b0, 1'b0, 4'h0});
  endfunction

  task automatic tick(input bit inf, input logic [N-1:0] rv, input logic [7*N-1:0] cw);
    oslot_t sl;
    logic [3:0] v;
    @(posedge clk); #1;
    if (auto_core && out_q.size() == 0 && m_tags.size() > 0) begin
      v = force_nib ? forced_val : 4'($urandom);
      force_nib = 1'b0;
      sched_nibble(v);
    end
    sl = '{1'b0, 1'b0, 1'b0, 4'h0};
    if (out_q.size() > 0) sl = out_q.pop_front();
    dec_in_flag = inf; req_valid = rv; req_cw = cw;
    dec_out_flag = sl.flag;
    dec_data_out = sl.flag ? sl.b : 1'($urandom);
    @(negedge clk);
    s_din = dec_data_in; s_rdy = req_ready; s_rv = res_valid; s_rd = res_data;
    s_rch = res_ch; s_err = err_ovf;
    e_rv = m_rv; e_rd = m_rd; e_rch = m_rch; e_err = m_err;
    model_step(inf, rv, cw, sl.done, sl.val, e_din, e_rdy);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; dec_in_flag = 0; req_valid = '0; dec_out_flag = 0; dec_data_out = 0;
    #20; @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dec_in_flag = 1; req_valid = '1; dec_out_flag = 1; req_cw = '1;
    #12;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if (dec_data_in !== 1'b0) begin errors++; $display("FAIL rst_din got %b exp 0", dec_data_in); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b exp 0", res_valid); end
    checks++; if (res_data !== 4'h0) begin errors++; $display("FAIL rst_rd got %h exp 0", res_data); end
    checks++; if (res_ch !== 1'b0) begin errors++; $display("FAIL rst_rch got %b exp 0", res_ch); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_ovf); end
  endtask

  task automatic test_single();
    logic [7*N-1:0] cw;
    logic [6:0] cw0, got;
    int rdy_cnt, hit;
    apply_reset();
    auto_core = 1; force_nib = 1; forced_val = 4'b1011;
    cw0 = 7'b1011000;
    cw = {7'h55, cw0};
    rdy_cnt = 0; hit = 0; got = '0;
    for (int j = 0; j < 45; j++) begin
      tick(1'b1, (j == 0) ? 2'b01 : 2'b00, cw);
      if (j >= 1 && j <= 7) got[7 - j] = s_din;
      if (s_rdy != '0) rdy_cnt++;
      if (s_rv && s_rd == 4'b1011 && s_rch == 0) hit++;
      checks++; if (s_din !== e_din) begin errors++; $display("FAIL single_din t=%0t got %b exp %b", $time, s_din, e_din); end
      checks++; if (s_rdy !== e_rdy) begin errors++; $display("FAIL single_ready t=%0t got %b exp %b", $time, s_rdy, e_rdy); end
      checks++; if (s_rv !== e_rv) begin errors++; $display("FAIL single_rv t=%0t got %b exp %b", $time, s_rv, e_rv); end
      if (e_rv) begin
        checks++; if (s_rd !== e_rd || s_rch !== e_rch) begin errors++; $display("FAIL single_res got %b/%0d exp %b/%0d", s_rd, s_rch, e_rd, e_rch); end
      end
    end
    checks++; if (got !== cw0) begin errors++; $display("FAIL single_bits got %b exp %b", got, cw0); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL single_ready_count got %0d exp 1", rdy_cnt); end
    checks++; if (hit !== 1) begin errors++; $display("FAIL single_result got %0d exp 1", hit); end
  endtask

  task automatic test_alternate();
    int unsigned grants[$];
    int unsigned results[$];
    apply_reset();
    auto_core = 1;
    for (int j = 0; j < 100; j++) begin
      tick(1'b1, 2'b11, 14'($urandom));
      if (s_rdy == 2'b01) grants.push_back(0);
      if (s_rdy == 2'b10) grants.push_back(1);
      if (s_rv) results.push_back(s_rch);
      checks++; if (s_rdy !== e_rdy) begin errors++; $display("FAIL alt_ready t=%0t got %b exp %b", $time, s_rdy, e_rdy); end
      checks++; if (s_din !== e_din) begin errors++; $display("FAIL alt_din t=%0t got %b exp %b", $time, s_din, e_din); end
      checks++; if (s_rv !== e_rv) begin errors++; $display("FAIL alt_rv t=%0t got %b exp %b", $time, s_rv, e_rv); end
      if (e_rv) begin
        checks++; if (s_rd !== e_rd || s_rch !== e_rch) begin errors++; $display("FAIL alt_res got %h/%0d exp %h/%0d", s_rd, s_rch, e_rd, e_rch); end
      end
    end
    checks++; if (grants.size() < 8 || results.size() < 8) begin errors++; $display("FAIL alt_count got %0d/%0d exp >=8", grants.size(), results.size()); end
    for (int i = 0; i < 8 && i < grants.size() && i < results.size(); i++) begin
      checks++; if (grants[i] !== i % 2) begin errors++; $display("FAIL alt_grant[%0d] got %0d exp %0d", i, grants[i], i % 2); end
      checks++; if (results[i] !== grants[i]) begin errors++; $display("FAIL alt_order[%0d] got %0d exp %0d", i, results[i], grants[i]); end
    end
  endtask

  task automatic test_idle();
    apply_reset();
    auto_core = 1;
    for (int j = 0; j < 50; j++) begin
      tick(1'($urandom_range(0, 3) != 0), 2'b00, 14'($urandom));
      checks++; if (s_din !== 1'b0) begin errors++; $display("FAIL idle_din t=%0t got %b exp 0", $time, s_din); end
      checks++; if (s_rdy !== '0) begin errors++; $display("FAIL idle_ready t=%0t got %b exp 0", $time, s_rdy); end
      checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL idle_rv t=%0t got %b exp 0", $time, s_rv); end
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL idle_err t=%0t got %b exp 0", $time, s_err); end
    end
  endtask

  task automatic test_stall();
    logic [7*N-1:0] cw;
    logic [6:0] c0;
    apply_reset();
    auto_core = 0;
    cw = 14'($urandom);
    c0 = cw[6:0];
    for (int j = 0; j < 14; j++) begin
      tick(!(j >= 4 && j <= 8), (j == 0) ? 2'b01 : 2'b00, cw);
      checks++; if (s_din !== e_din) begin errors++; $display("FAIL stall_din t=%0t got %b exp %b", $time, s_din, e_din); end
      checks++; if (s_rdy !== e_rdy) begin errors++; $display("FAIL stall_ready t=%0t got %b exp %b", $time, s_rdy, e_rdy); end
      if (j >= 4 && j <= 8) begin
        checks++; if (s_din !== c0[3]) begin errors++; $display("FAIL stall_hold t=%0t got %b exp %b", $time, s_din, c0[3]); end
      end
    end
  endtask

  task automatic test_stuck();
    logic [3:0] v;
    int rv_cnt;
    apply_reset();
    auto_core = 0;
    for (int j = 0; j < 8; j++) tick(1'b1, (j == 0) ? 2'b10 : 2'b00, 14'($urandom));
    v = 4'($urandom);
    for (int b = 3; b >= 0; b--) out_q.push_back('{1'b1, v[b], b == 0, v});
    out_q.push_back('{1'b1, ~v[0], 1'b0, 4'h0});
    out_q.push_back('{1'b1, v[1], 1'b0, 4'h0});
    rv_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 2'b00, '0);
      if (s_rv) begin
        rv_cnt++;
        checks++; if (s_rd !== v || s_rch !== 1) begin errors++; $display("FAIL stuck_res got %b/%0d exp %b/1", s_rd, s_rch, v); end
      end
      checks++; if (s_rv !== e_rv) begin errors++; $display("FAIL stuck_rv t=%0t got %b exp %b", $time, s_rv, e_rv); end
    end
    checks++; if (rv_cnt !== 1) begin errors++; $display("FAIL stuck_count got %0d exp 1", rv_cnt); end
  endtask

  task automatic test_random();
    apply_reset();
    auto_core = 1;
    for (int j = 0; j < 500; j++) begin
      tick(1'($urandom_range(0, 3) != 0), 2'($urandom), 14'($urandom));
      checks++; if (s_din !== e_din) begin errors++; $display("FAIL rnd_din t=%0t got %b exp %b", $time, s_din, e_din); end
      checks++; if (s_rdy !== e_rdy) begin errors++; $display("FAIL rnd_ready t=%0t got %b exp %b", $time, s_rdy, e_rdy); end
      checks++; if (s_rv !== e_rv) begin errors++; $display("FAIL rnd_rv t=%0t got %b exp %b", $time, s_rv, e_rv); end
      checks++; if (s_err !== e_err) begin errors++; $display("FAIL rnd_err t=%0t got %b exp %b", $time, s_err, e_err); end
      if (e_rv) begin
        checks++; if (s_rd !== e_rd || s_rch !== e_rch) begin errors++; $display("FAIL rnd_res got %h/%0d exp %h/%0d", s_rd, s_rch, e_rd, e_rch); end
      end
    end
  endtask

  task automatic test_ovf_reset();
    apply_reset();
    auto_core = 0;
    for (int j = 1; j <= 40; j++) begin
      tick(1'b1, 2'($urandom), 14'($urandom));
      checks++; if (s_err !== e_err) begin errors++; $display("FAIL ovf_err t=%0t got %b exp %b", $time, s_err, e_err); end
      checks++; if (s_rdy !== e_rdy) begin errors++; $display("FAIL ovf_ready t=%0t got %b exp %b", $time, s_rdy, e_rdy); end
      if (j == 36) begin
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", s_err); end
      end
      if (j == 37) begin
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL ovf_after got %b exp 1", s_err); end
      end
    end
    // asynchronous reset between edges
    req_valid = 2'b11; req_cw = '1; dec_in_flag = 1'b1; dec_out_flag = 1'b1;
    #2; rst_n = 1'b0; #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL arst_ready got %b exp 0", req_ready); end
    checks++; if (dec_data_in !== 1'b0) begin errors++; $display("FAIL arst_din got %b exp 0", dec_data_in); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_rv got %b exp 0", res_valid); end
    checks++; if (res_data !== 4'h0 || res_ch !== 1'b0) begin errors++; $display("FAIL arst_res got %h/%b exp 0/0", res_data, res_ch); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", err_ovf); end
    apply_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_idle();
    test_stall();
    test_stuck();
    test_random();
    test_ovf_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_share_ctrl.md
# dec_share_ctrl

Round-robin scheduler that shares one serial (7,4) cyclic decoder core between `N_CH` codeword requesters. It serializes granted 7-bit codewords MSB-first into the core under the core's `in_flag` throttle and inserts all-zero filler codewords when no request is pending, because the core consumes a bit on every `in_flag` cycle. It deserializes the core's 4-bit serial results and returns each result tagged with the originating channel, in grant order. It sits between the channel front-ends and the decoder core in the decoder subsystem.

## Interface
- `N_CH`, 2: number of requesters; legal range 2..4.
- `CH_W`, `$clog2(N_CH)`: channel-id width; derived, do not override.
- `TAG_DEPTH`, 4: depth of the in-flight tag FIFO; power of two.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_CH  per-channel codeword available.
- `req_cw`  in  7*N_CH  codeword of channel i at `[7i+6:7i]`; bit 6 is sent first.
- `req_ready`  out  N_CH  one-hot, 1-cycle pulse; the codeword is taken in that cycle.
- `dec_data_in`  out  1  serial bit to the core.
- `dec_in_flag`  in  1  core accepts `dec_data_in` this cycle.
- `dec_data_out`  in  1  serial result bit from the core.
- `dec_out_flag`  in  1  core result bit valid.
- `res_valid`  out  1  1-cycle pulse; result available.
- `res_data`  out  4  decoded nibble; bit 3 is the first serial bit.
- `res_ch`  out  CH_W  channel of `res_data`.
- `err_ovf`  out  1  sticky; tag FIFO overflow.

## Operation
- **Feed path.** 7-bit shift register `tx_sr` and 3-bit `tx_cnt` (0..6). `dec_data_in = tx_sr[6]`.
  - On each cycle with `dec_in_flag=1`: shift left and increment `tx_cnt`.
  - With `dec_in_flag=0`: hold.
  - When `tx_cnt==6` and `dec_in_flag=1` (last bit consumed), the boundary event fires in the same cycle:
    - arbitrate and load the next codeword;
    - `tx_cnt` becomes 0;
    - push a tag for the codeword just completed.
- **Arbitration.** Round-robin pointer `rr`. The winner is the first `req_valid[i]` found starting at `rr`.
  - On grant: load `req_cw` into `tx_sr`, pulse `req_ready[i]`, set `rr` to i+1 mod `N_CH`.
  - With no valid request: load `7'b0000000` as filler, mark it idle, leave `rr` unchanged.
- **Start-up.** After reset, `tx_sr` holds filler and an arbitration occurs at the first `dec_in_flag=1` cycle. That first filler is discarded with no tag.
- **Tag FIFO.** Entry is `{idle, ch}`, `TAG_DEPTH` entries.
  - Push at every boundary event.
  - Pop when a result nibble completes.
  - Simultaneous push and pop in one cycle: occupancy unchanged.
  - Push when full: the entry is dropped and `err_ovf` is set; `err_ovf` is cleared only by reset.
  - Result completes while empty: the result is discarded and `err_ovf` is set.
- **Collect path.** 4-bit `rx_sr` and 2-bit `rx_cnt`.
  - Each cycle with `dec_out_flag=1` and the collector armed: shift in `dec_data_out` and increment `rx_cnt`.
  - At the 4th bit: the nibble is complete; pop the tag and disarm.
  - Re-arm when `dec_out_flag` is sampled 0, so extra asserted cycles are ignored.
  - If the popped tag is not idle: `res_valid=1`, `res_data={rx_sr[2:0], dec_data_out}`, `res_ch=tag.ch`. Idle results are dropped silently.
- **FSM.** Collector states are ARMED → SHIFT → HOLD (wait for `out_flag` low) → ARMED. The feed side is counter-driven and has no FSM.

## Timing
- **Reset values:** `req_ready=0`, `dec_data_in=0`, `res_valid=0`, `res_data=0`, `res_ch=0`, `err_ovf=0`; `rr=0`, FIFO empty, collector ARMED.
- `req_ready` asserts in the same cycle as the boundary event. A request needs at least 7 `in_flag` cycles between grants.
- `res_valid` is registered, one cycle after the 4th `dec_out_flag` bit is sampled.
- `req_valid` deasserting mid-codeword has no effect; the codeword already loaded completes.
- Reset mid-operation abandons all in-flight codewords; no `res_valid` is produced for them.

## Structure
- Shared package `dec_pkg`:
  - `CW_W=7`, `MSG_W=4`, `FILL_CW=7'b0`;
  - typedef `tag_t {logic idle; logic [1:0] ch;}`;
  - collector state enum.
- One sub-module: `dec_tag_fifo`, a synchronous FIFO with full/empty and overflow flag, async active-low reset.

## Test plan
- Channel 0 only, `req_cw=7'b1011000`, `dec_in_flag` held 1 → `req_ready[0]` pulses once; `dec_data_in` shows 1,0,1,1,0,0,0; a core result nibble `1011` returns `res_valid` with `res_data=4'b1011`, `res_ch=0`.
- Both channels valid continuously → grants alternate 0,1,0,1; `res_ch` order matches grant order over 8 codewords.
- No requests → filler is streamed; `dec_data_in=0`, no `req_ready`, no `res_valid`, `err_ovf` stays 0.
- `dec_in_flag` low for 5 cycles mid-codeword at `tx_cnt=3` → `dec_data_in` holds bit 3; remaining bits resume in order; no extra `req_ready`.
- `dec_out_flag` stuck high for 6 cycles → exactly one nibble is captured and one `res_valid` is produced.
- Push 5 tags without any core output → `err_ovf=1` at the 5th boundary; assert `rst_n=0` mid-stream → all outputs return to reset values asynchronously.
